// File: rtl/ffmul_pkg.sv
// Shared definitions for the ffmul transaction sequencer: field codes,
// sequencer states and per-field beat/width lookups.
package ffmul_pkg;

  typedef enum logic [1:0] {
    FF409 = 2'd0,
    FF233 = 2'd1,
    FF193 = 2'd2,
    FF113 = 2'd3
  } ff_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MUL,
    DRAIN
  } seq_state_e;

  // Widest field supported by the multiplier, and beat index width.
  localparam int unsigned FW_MAX = 409;
  localparam int unsigned IDX_W  = 4;

  // Number of 32-bit beats per operand/result for a field.
  function automatic logic [IDX_W-1:0] ff_beats(input ff_op_e op);
    case (op)
      FF409:   return 4'd13;
      FF233:   return 4'd8;
      FF193:   return 4'd7;
      default: return 4'd4;
    endcase
  endfunction

  // Field width in bits.
  function automatic int unsigned ff_width(input ff_op_e op);
    case (op)
      FF409:   return 409;
      FF233:   return 233;
      FF193:   return 193;
      default: return 113;
    endcase
  endfunction

endpackage

// File: rtl/ffmul_seq_regfile.sv
// Operand A/B and result storage with beat-indexed write/read and
// field-width masking of everything presented to the outside.
module ffmul_seq_regfile
  import ffmul_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned MAXW = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  ff_op_e            op_i,
  input  logic              clr_ab_i,
  input  logic              wr_a_i,
  input  logic              wr_b_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic              res_we_i,
  input  logic [FW_MAX-1:0] res_i,
  output logic [FW_MAX-1:0] mul_a_o,
  output logic [FW_MAX-1:0] mul_b_o,
  output logic [DW-1:0]     rd_data_o
);

  localparam int unsigned BW = $clog2(DW);

  if (MAXW * DW < FW_MAX) begin : g_maxw_chk
    $error("ffmul_seq_regfile: MAXW*DW must cover the widest field");
  end

  logic [FW_MAX-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [FW_MAX-1:0] mask;

  // Bits below the latched field width are live; the rest read as 0.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FW_MAX; i++) begin
      mask[i] = (i < ff_width(op_i));
    end
  end

  // Beat write: only the 409 stored bits are addressable, so the pad bits
  // of the top beat are dropped on write rather than stored.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clr_ab_i) begin
      a_d = '0;
      b_d = '0;
    end
    for (int unsigned i = 0; i < FW_MAX; i++) begin
      if (idx_i == IDX_W'(i / DW)) begin
        if (wr_a_i) a_d[i] = wr_data_i[BW'(i % DW)];
        if (wr_b_i) b_d[i] = wr_data_i[BW'(i % DW)];
      end
    end
    res_d = res_we_i ? res_i : res_q;
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  // Beat read of the masked result; missing top-beat bits stay 0.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < FW_MAX; i++) begin
      if (idx_i == IDX_W'(i / DW)) begin
        rd_data_o[BW'(i % DW)] = res_q[i] & mask[i];
      end
    end
  end

  assign mul_a_o = a_q & mask;
  assign mul_b_o = b_q & mask;

endmodule

// File: rtl/ffmul_seq_ctl.sv
// Streaming front end for the shared ffmul multiplier: command, A/B operand
// beats in, multiplier handshake, result beats out.
// Optional MUL-state timeout abort enabled by defining FFSEQ_TIMEOUT_EN.
module ffmul_seq_ctl
  import ffmul_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned MAXW    = 13,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic [408:0]      mul_a_o,
  output logic [408:0]      mul_b_o,
  output logic [1:0]        mul_op_o,
  output logic              mul_en_o,
  input  logic [408:0]      mul_result_i,
  input  logic              mul_finish_p_i,
  output logic              err_o
);

  if (DW != 32) begin : g_dw_chk
    $error("ffmul_seq_ctl: DW must be 32");
  end
  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("ffmul_seq_ctl: TIMEOUT must be at least 2");
  end

  seq_state_e       state_q, state_d;
  ff_op_e           op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] n_beats;
  logic             last_idx;
  logic             cmd_rdy, clr_ab, wr_a, wr_b, res_we;
  logic             tmo;

  assign n_beats  = ff_beats(op_q);
  assign last_idx = (idx_q == n_beats - 1'b1);

`ifdef FFSEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  // Cycle counter is held at 0 outside MUL, so it starts from 0 on entry;
  // a finish pulse on the timeout cycle takes priority over the abort.
  always_comb begin
    cnt_d = (state_q == MUL) ? cnt_q + 1'b1 : '0;
    err_d = (state_q == MUL) && tmo && !mul_finish_p_i;
  end

  // Timeout counter and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  // Next-state, beat index and handshake decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    cmd_rdy     = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    mul_en_o    = 1'b0;
    clr_ab      = 1'b0;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    res_we      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_valid_i) begin
          op_d    = ff_op_e'(cmd_op_i);
          clr_ab  = 1'b1;
          idx_d   = '0;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_a = 1'b1;
          if (last_idx) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_b = 1'b1;
          if (last_idx) begin
            idx_d   = '0;
            state_d = MUL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      MUL: begin
        mul_en_o = 1'b1;
        if (mul_finish_p_i) begin
          res_we  = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched field code and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= FF409;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  // IDLE normally advertises ready; masked by reset so every output reads 0.
  assign cmd_ready_o = cmd_rdy && !rst;
  assign out_last_o  = out_valid_o && last_idx;
  assign busy_o      = (state_q != IDLE);
  assign mul_op_o    = op_q;

  ffmul_seq_regfile #(
    .DW   (DW),
    .MAXW (MAXW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .op_i      (op_q),
    .clr_ab_i  (clr_ab),
    .wr_a_i    (wr_a),
    .wr_b_i    (wr_b),
    .idx_i     (idx_q),
    .wr_data_i (in_data_i),
    .res_we_i  (res_we),
    .res_i     (mul_result_i),
    .mul_a_o   (mul_a_o),
    .mul_b_o   (mul_b_o),
    .rd_data_o (out_data_o)
  );

endmodule

// File: tb/tb_ffmul_seq_ctl.sv
// Directed bench for ffmul_seq_ctl.
module tb_ffmul_seq_ctl;

  typedef logic [415:0] v_t;

`ifdef FFSEQ_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op = 2'd0;
  logic         in_valid = 1'b0;
  logic         in_ready_o;
  logic [31:0]  in_data = '0;
  logic         out_valid_o;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data_o;
  logic         out_last_o;
  logic         busy_o;
  logic [408:0] mul_a_o, mul_b_o;
  logic [1:0]   mul_op_o;
  logic         mul_en_o;
  logic [408:0] mul_result = '0;
  logic         mul_finish = 1'b0;
  logic         err_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ffmul_seq_ctl #(
    .DW      (32),
    .MAXW    (13),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_op_o       (mul_op_o),
    .mul_en_o       (mul_en_o),
    .mul_result_i   (mul_result),
    .mul_finish_p_i (mul_finish),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Optional command handshake, then n A beats and nb B beats back to back.
  task automatic load(input bit do_cmd, input logic [1:0] op, input v_t a, input v_t b,
                      input int unsigned n, input int unsigned nb);
    if (do_cmd) begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      step();
      cmd_valid = 1'b0;
    end
    chk("accept_busy", v_t'(busy_o), v_t'(1));
    chk("accept_in_ready", v_t'(in_ready_o), v_t'(1));
    chk("accept_op", v_t'(mul_op_o), v_t'(op));
    for (int unsigned k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = a[k*32 +: 32];
      step();
    end
    for (int unsigned k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      in_data  = b[k*32 +: 32];
      step();
    end
    in_valid = 1'b0;
  endtask

  // Holds the finish pulse back d cycles after MUL entry, counting mul_en cycles.
  task automatic finish_after(input int unsigned d, input logic [408:0] res,
                              output int unsigned en_cycles);
    en_cycles = 0;
    for (int unsigned i = 0; i < d; i++) begin
      if (mul_en_o) en_cycles++;
      step();
    end
    if (mul_en_o) en_cycles++;
    mul_finish = 1'b1;
    mul_result = res;
    step();
    if (mul_en_o) en_cycles++;
    mul_finish = 1'b0;
  endtask

  task automatic drain(input int unsigned n, input v_t exp, input int unsigned stall_at,
                       input int unsigned stall_len, input bit blocked);
    out_ready = 1'b1;
    for (int unsigned b = 0; b < n; b++) begin
      chk($sformatf("out_valid[%0d]", b), v_t'(out_valid_o), v_t'(1));
      chk($sformatf("out_data[%0d]", b), v_t'(out_data_o), v_t'(exp[b*32 +: 32]));
      chk($sformatf("out_last[%0d]", b), v_t'(out_last_o), v_t'(b == n - 1));
      if (blocked) begin
        chk($sformatf("drain_cmd_ready[%0d]", b), v_t'(cmd_ready_o), v_t'(0));
        chk($sformatf("drain_in_ready[%0d]", b), v_t'(in_ready_o), v_t'(0));
      end
      if (b == stall_at) begin
        out_ready = 1'b0;
        for (int unsigned s = 0; s < stall_len; s++) begin
          step();
          chk($sformatf("stall_valid[%0d]", s), v_t'(out_valid_o), v_t'(1));
          chk($sformatf("stall_data[%0d]", s), v_t'(out_data_o), v_t'(exp[b*32 +: 32]));
        end
        out_ready = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    chk("drain_done_valid", v_t'(out_valid_o), v_t'(0));
    chk("drain_done_cmd_ready", v_t'(cmd_ready_o), v_t'(1));
    chk("drain_done_busy", v_t'(busy_o), v_t'(0));
  endtask

  initial begin
    v_t           a, b, r, e;
    logic [408:0] ones;
    int unsigned  en_cyc;

    // Reset state
    #1;
    chk("rst_cmd_ready", v_t'(cmd_ready_o), v_t'(0));
    chk("rst_busy", v_t'(busy_o), v_t'(0));
    chk("rst_mul_en", v_t'(mul_en_o), v_t'(0));
    chk("rst_mul_op", v_t'(mul_op_o), v_t'(0));
    chk("rst_out_valid", v_t'(out_valid_o), v_t'(0));
    chk("rst_mul_a", v_t'(mul_a_o), v_t'(0));
    step();
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", v_t'(cmd_ready_o), v_t'(1));
    chk("idle_in_ready", v_t'(in_ready_o), v_t'(0));

    // FF113: 4-beat operands, finish 3 cycles after enable, masked top beat
    a = v_t'(128'h00000004_00000003_00000002_00000001);
    b = v_t'(128'h00000008_00000007_00000006_00000005);
    load(1'b1, 2'd3, a, b, 4, 4);
    chk("ff113_mul_a", v_t'(mul_a_o), a);
    chk("ff113_mul_b", v_t'(mul_b_o), b);
    chk("ff113_mul_en", v_t'(mul_en_o), v_t'(1));
    r = '0;
    for (int unsigned w = 0; w < 13; w++) r[w*32 +: 32] = 32'hAAAA_AAAA;
    finish_after(3, r[408:0], en_cyc);
    chk("ff113_en_cycles", v_t'(en_cyc), v_t'(4));
    e = v_t'(128'h0000AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA);
    drain(4, e, 99, 0, 1'b0);
    chk("err_low_1", v_t'(err_o), v_t'(0));

    // FF409 all ones, backpressure at beat 2, cmd/in requests during DRAIN
    ones = '1;
    a = '1;
    load(1'b1, 2'd0, a, a, 13, 13);
    chk("ff409_mul_a_ones", v_t'(mul_a_o), v_t'(ones));
    chk("ff409_mul_b_ones", v_t'(mul_b_o), v_t'(ones));
    r = '0;
    for (int unsigned w = 0; w < 13; w++) r[w*32 +: 32] = 32'h1111_1111 * (w + 1);
    finish_after(1, r[408:0], en_cyc);
    chk("ff409_en_cycles", v_t'(en_cyc), v_t'(2));
    e = r;
    e[415:384] = 32'h01DD_DDDD;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    drain(13, e, 2, 5, 1'b1);
    in_valid = 1'b0;
    step();
    cmd_valid = 1'b0;

    // FF233 accepted straight after drain; reset during LOAD_B
    for (int unsigned k = 0; k < 8; k++) a[k*32 +: 32] = 32'hA5A5_0000 + k;
    load(1'b0, 2'd1, a, a, 8, 3);
    chk("ff233_in_ready_loadb", v_t'(in_ready_o), v_t'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", v_t'(busy_o), v_t'(0));
    chk("mid_rst_cmd_ready", v_t'(cmd_ready_o), v_t'(0));
    chk("mid_rst_in_ready", v_t'(in_ready_o), v_t'(0));
    chk("mid_rst_mul_en", v_t'(mul_en_o), v_t'(0));
    chk("mid_rst_mul_a", v_t'(mul_a_o), v_t'(0));
    chk("mid_rst_mul_b", v_t'(mul_b_o), v_t'(0));
    chk("mid_rst_mul_op", v_t'(mul_op_o), v_t'(0));
    chk("mid_rst_out", v_t'({out_valid_o, out_last_o, out_data_o, err_o}), v_t'(0));
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", v_t'(cmd_ready_o), v_t'(1));

    // Finish pulse in IDLE is ignored
    mul_finish = 1'b1;
    step();
    mul_finish = 1'b0;
    chk("idle_finish_busy", v_t'(busy_o), v_t'(0));
    chk("idle_finish_valid", v_t'(out_valid_o), v_t'(0));

    // FF193: width masking on A, B and result, immediate finish
    a = '1;
    b = '0;
    for (int unsigned k = 0; k < 7; k++) b[k*32 +: 32] = k + 1;
    load(1'b1, 2'd2, a, b, 7, 7);
    e = '0;
    e[192:0] = '1;
    chk("ff193_mul_a", v_t'(mul_a_o), e);
    chk("ff193_mul_b", v_t'(mul_b_o),
        v_t'(224'h00000001_00000006_00000005_00000004_00000003_00000002_00000001));
    r = '0;
    for (int unsigned w = 0; w < 13; w++) r[w*32 +: 32] = 32'h1111_1111 * (w + 1);
    finish_after(0, r[408:0], en_cyc);
    chk("ff193_en_cycles", v_t'(en_cyc), v_t'(1));
    e = v_t'(224'h00000001_66666666_55555555_44444444_33333333_22222222_11111111);
    drain(7, e, 99, 0, 1'b0);
    chk("err_low_2", v_t'(err_o), v_t'(0));

`ifdef FFSEQ_TIMEOUT_EN
    // Timeout abort with no finish pulse
    begin
      int unsigned n;
      bit          saw_valid;
      a = v_t'(128'h1);
      load(1'b1, 2'd3, a, a, 4, 4);
      n = 0;
      saw_valid = 1'b0;
      while (err_o == 1'b0 && n < 64) begin
        if (out_valid_o) saw_valid = 1'b1;
        step();
        n++;
      end
      chk("tmo_cycles", v_t'(n), v_t'(16));
      chk("tmo_busy", v_t'(busy_o), v_t'(0));
      chk("tmo_mul_en", v_t'(mul_en_o), v_t'(0));
      chk("tmo_no_valid", v_t'({saw_valid, out_valid_o}), v_t'(0));
      step();
      chk("tmo_err_single", v_t'(err_o), v_t'(0));
      chk("tmo_idle_ready", v_t'(cmd_ready_o), v_t'(1));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required completion within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
